led_pattern_ctrl: RTL
=====================

Name: led_pattern_ctrl

Overview:
Parametrised LED pattern engine: programmable-rate tick prescaler, four-mode pattern generator (flash, shift, double shift, ping-pong) and an N-colour channel router. Mode and colour are chosen by edge-detected buttons. Instantiated in top-level board wrappers, replacing a separate counter, per-pattern blocks and glue mux. Button/switch sources (hardware or VIO) are muxed outside this block.

Parameters:
NB_LEDS, 4, LEDs per colour channel (>=2)
NB_COUNTER, 32, prescaler counter width
NB_SPEED, 3, width of speed select
BASE_PERIOD, 2**20, tick period in clocks at speed 0 (>=1)
NB_COLORS, 3, number of colour channels (R,G,B order, index 0 = R)
DB_CYCLES, 16, debounce stable-count (used only with optional feature)

Ports:
clock  in  1  system clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_btn  in  NB_COLORS+1  [0] = next mode; [NB_COLORS:1] = one-hot colour select
i_speed  in  NB_SPEED  tick period select
i_reverse  in  1  shift direction (0 = left/up, 1 = right/down)
o_led_rgb  out  NB_COLORS*NB_LEDS  channel c occupies bits [c*NB_LEDS +: NB_LEDS]
o_tick  out  1  one-cycle pulse per pattern step
o_mode  out  2  current mode
o_color  out  clog2(NB_COLORS) (min 1)  current colour index

Behaviour:
- Reset (i_reset low, async): counter=0, o_tick=0, mode=FLASH(0), colour=0, pattern=all-zero, direction=up, sync/edge regs=0. o_led_rgb=0.
- Buttons: each bit passes a 2-FF synchroniser, then rising-edge detection (synced & ~previous). Held button = one event. State update on the 3rd rising clock edge after input goes high.
- Prescaler: limit = BASE_PERIOD << i_speed, saturated to 2**NB_COUNTER-1. Counter increments each cycle. When count >= limit-1: o_tick=1 for that cycle (registered, same edge counter clears to 0). Speed change mid-count takes effect immediately via the >= compare; no tick is lost or doubled beyond one.
- Mode FSM: FLASH(0) -> SHIFT(1) -> SHIFT2(2) -> PINGPONG(3) -> FLASH on mode event. Mode event also reloads the new mode's seed pattern and clears the counter (next tick a full period later).
- Seeds: FLASH all-zero; SHIFT 0..01; SHIFT2 0..011; PINGPONG 0..01 with direction up.
- Step on tick: FLASH inverts all bits. SHIFT/SHIFT2 rotate by 1 (left if i_reverse=0, right if 1), wrap-around. PINGPONG: one hot bit moves toward MSB while up, toward LSB while down; on reaching bit NB_LEDS-1 direction flips to down, at bit 0 flips to up (endpoint shown for exactly one tick, no repeat); i_reverse ignored.
- Tick and mode event in same cycle: mode event wins (seed loaded, tick discarded).
- Colour: event on exactly one bit of i_btn[NB_COLORS:1] sets colour to that index-1; zero or multiple simultaneous colour events leave colour unchanged. Colour and mode events in the same cycle are both applied.
- Output: o_led_rgb channel c = pattern when colour==c, else 0. Gating from registers only; no added latency.
- o_mode/o_color mirror internal registers.

Optional Feature:
Macro LED_PAT_DEBOUNCE_EN. Defined: after synchronisation each button has a counter; debounced value updates only after the synced value differs from it for DB_CYCLES consecutive cycles (glitch restarts count); edge detection on debounced value; latency = 3 + DB_CYCLES edges. Undefined: debounced = synced, DB_CYCLES unused, no counters synthesised.

Test Plan:
- Reset: BASE_PERIOD=4, i_speed=0, release reset -> o_tick every 4 clocks; o_led_rgb=0x000 then R channel alternates 0x0/0xF each tick; o_mode=0, o_color=0.
- Mode cycle: pulse i_btn[0] for 5 clocks, four times -> o_mode 1,2,3,0; seeds 0001, 0011, 0001, 0000; each held pulse counts once.
- Shift/reverse: mode SHIFT, i_reverse=0 -> 0001,0010,0100,1000,0001; set i_reverse=1 -> 1000 steps to 0100; SHIFT2 left from 1001 -> 0011.
- Ping-pong: NB_LEDS=4 -> 0001,0010,0100,1000,0100,0010,0001,0010; i_reverse toggling has no effect.
- Colour: press i_btn[2] -> o_color=1, pattern in bits [7:4], others 0; press i_btn[1]+i_btn[3] together -> colour stays 1; press i_btn[3] -> o_color=2.
- Speed/corner: i_speed 0->3 at count 2 -> next tick at count 31; mode event on tick cycle -> seed loaded, no step; assert i_reset mid-pattern -> all outputs 0 immediately; with LED_PAT_DEBOUNCE_EN, 10-cycle glitch (DB_CYCLES=16) -> no mode change.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: prescaled four-mode LED pattern engine with button-driven mode/colour routing.
// Optional debounce stage enabled by defining LED_PAT_DEBOUNCE_EN.
module led_pattern_ctrl #(
  parameter int          NB_LEDS     = 4,
  parameter int          NB_COUNTER  = 32,
  parameter int          NB_SPEED    = 3,
  parameter int unsigned BASE_PERIOD = 2**20,
  parameter int          NB_COLORS   = 3,
  parameter int          DB_CYCLES   = 16,
  localparam int         CW          = (NB_COLORS > 1) ? $clog2(NB_COLORS) : 1
) (
  input  logic                          clock,
  input  logic                          i_reset,
  input  logic [NB_COLORS:0]            i_btn,
  input  logic [NB_SPEED-1:0]           i_speed,
  input  logic                          i_reverse,
  output logic [NB_COLORS*NB_LEDS-1:0]  o_led_rgb,
  output logic                          o_tick,
  output logic [1:0]                    o_mode,
  output logic [CW-1:0]                 o_color
);
  typedef enum logic [1:0] {FLASH, SHIFT, SHIFT2, PINGPONG} mode_t;
  localparam int LW = NB_COUNTER + 32 + 2**NB_SPEED;
  logic [NB_COLORS:0]    btn_s1_q, btn_s2_q, btn_prev_q, btn_db, btn_edge;
  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  logic                  tick_q, tick_d, dir_q, dir_d, hit, mode_ev;
  mode_t                 mode_q, mode_d;
  logic [NB_LEDS-1:0]    pat_q, pat_d;
  logic [CW-1:0]         color_q, color_d, col_sel;
  logic [NB_COLORS-1:0]  col_ev;
  logic [LW-1:0]         lim_raw, lim_w;
  always_ff @(posedge clock or negedge i_reset)
    if (!i_reset) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      btn_s1_q   <= i_btn;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_db;
    end
`ifdef LED_PAT_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  logic [NB_COLORS:0][DBW-1:0] db_cnt_q;
  logic [NB_COLORS:0]          btn_db_q;
  // Any cycle where synced equals debounced restarts the stability count
  always_ff @(posedge clock or negedge i_reset)
    if (!i_reset) begin
      db_cnt_q <= '0;
      btn_db_q <= '0;
    end else begin
      for (int b = 0; b <= NB_COLORS; b++)
        if (btn_s2_q[b] != btn_db_q[b]) begin
          if (db_cnt_q[b] == DBW'(DB_CYCLES - 1)) begin
            btn_db_q[b] <= btn_s2_q[b];
            db_cnt_q[b] <= '0;
          end else db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
        end else db_cnt_q[b] <= '0;
    end
  assign btn_db = btn_db_q;
`else
  assign btn_db = btn_s2_q;
`endif
  assign btn_edge = btn_db & ~btn_prev_q;
  assign mode_ev  = btn_edge[0];
  assign col_ev   = btn_edge[NB_COLORS:1];
  // Limit computed wide so the shift never overflows before saturation
  assign lim_raw = LW'(BASE_PERIOD) << i_speed;
  assign lim_w   = (lim_raw > LW'({NB_COUNTER{1'b1}})) ? LW'({NB_COUNTER{1'b1}}) : lim_raw;
  assign hit     = (LW'(cnt_q) + LW'(1)) >= lim_w;
  always_comb begin
    cnt_d   = (mode_ev | hit) ? '0 : cnt_q + 1'b1;
    tick_d  = hit & ~mode_ev;
    mode_d  = mode_ev ? mode_t'(mode_q + 2'd1) : mode_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    col_sel = '0;
    for (int i = 0; i < NB_COLORS; i++)
      if (col_ev[i]) col_sel = CW'(i);
    color_d = $onehot(col_ev) ? col_sel : color_q;
    if (mode_ev) begin
      pat_d = (mode_d == FLASH) ? '0 : (mode_d == SHIFT2) ? NB_LEDS'(3) : NB_LEDS'(1);
      dir_d = 1'b0;
    end else if (hit)
      case (mode_q)
        FLASH:    pat_d = ~pat_q;
        PINGPONG: begin
          pat_d = dir_q ? pat_q >> 1 : pat_q << 1;
          dir_d = dir_q ? ~pat_q[1] : pat_q[NB_LEDS-2];
        end
        default:  pat_d = i_reverse ? {pat_q[0], pat_q[NB_LEDS-1:1]} : {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
      endcase
  end
  always_ff @(posedge clock or negedge i_reset)
    if (!i_reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      mode_q  <= FLASH;
      pat_q   <= '0;
      dir_q   <= 1'b0;
      color_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      color_q <= color_d;
    end
  for (genvar c = 0; c < NB_COLORS; c++) begin : g_ch
    assign o_led_rgb[c*NB_LEDS +: NB_LEDS] = (color_q == CW'(c)) ? pat_q : '0;
  end
  assign o_tick  = tick_q;
  assign o_mode  = mode_q;
  assign o_color = color_q;
endmodule
